// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the AHB-to-APB bridge controller.
// The error-response states are only encoded when BRIDGE_ERR_RESP_EN is defined.
package ahb_apb_pkg;

    localparam int NSLV = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WWAIT  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3
`ifdef BRIDGE_ERR_RESP_EN
        ,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
`endif
    } state_t;

    // Only NONSEQ and SEQ carry a real transfer; IDLE and BUSY never start one.
    function automatic logic htrans_active(input logic [1:0] htrans);
        logic act;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
            default:                   act = 1'b0;
        endcase
        return act;
    endfunction

    function automatic logic [1:0] hresp_code(input logic err);
        return err ? HRESP_ERROR : HRESP_OKAY;
    endfunction

endpackage

// File: rtl/ahb_apb_addr_decode.sv
// Combinational decode of the upper AHB address bits into a mapped flag and
// the index of one of the consecutive APB slave windows.
module ahb_apb_addr_decode
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          SLV_AW    = 26
) (
    input  logic [31:SLV_AW]        i_haddr_hi,
    output logic                    o_mapped,
    output logic [$clog2(NSLV)-1:0] o_idx
);

    assign o_mapped = (i_haddr_hi[31:SLV_AW+2] == BASE_ADDR[31:SLV_AW+2]);
    assign o_idx    = i_haddr_hi[SLV_AW+1:SLV_AW];

endmodule

// File: rtl/ahb_apb_bridge_ctrl.sv
// AHB-slave to APB-master bridge controller for four APB peripherals.
// Optional macro BRIDGE_ERR_RESP_EN: unmapped transfers get a two-cycle ERROR response.
module ahb_apb_bridge_ctrl
    import ahb_apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          SLV_AW    = 26
) (
    input  logic            clk,
    input  logic            Hrstn,
    input  logic [1:0]      Htrans,
    input  logic            Hwrite,
    input  logic            Hreadyin,
    input  logic [31:0]     Haddr,
    input  logic [31:0]     Hwdata,
    output logic            Hreadyout,
    output logic [1:0]      Hresp,
    output logic [31:0]     Hrdata,
    output logic [NSLV-1:0] Psel,
    output logic            Penable,
    output logic            Pwrite,
    output logic [31:0]     Paddr,
    output logic [31:0]     Pwdata,
    input  logic [31:0]     Prdata
);

    state_t          r_state, w_state_nxt, w_acc_state;
    logic            w_mapped, w_xfer, w_acc_load, w_acc_zero;
    logic [1:0]      w_dec_idx, r_idx, w_idx_nxt;
    logic [31:0]     r_paddr, w_paddr_nxt, r_pwdata, w_pwdata_nxt, r_hrdata, w_hrdata_nxt;
    logic            r_pwrite, w_pwrite_nxt;
    logic            r_hready, w_hready_nxt, r_penable, w_penable_nxt, w_err_nxt;
    logic [1:0]      r_hresp;
    logic [NSLV-1:0] r_psel, w_psel_nxt;

    ahb_apb_addr_decode #(
        .BASE_ADDR (BASE_ADDR),
        .SLV_AW    (SLV_AW)
    ) u_decode (
        .i_haddr_hi (Haddr[31:SLV_AW]),
        .o_mapped   (w_mapped),
        .o_idx      (w_dec_idx)
    );

    assign w_xfer = Hreadyin && htrans_active(Htrans);

    // Outcome of an address phase seen in a state that can accept a transfer.
    always_comb begin
        w_acc_state = ST_IDLE;
        w_acc_load  = 1'b0;
        w_acc_zero  = 1'b0;
        if (w_xfer) begin
            if (w_mapped) begin
                w_acc_load  = 1'b1;
                w_acc_state = Hwrite ? ST_WWAIT : ST_SETUP;
            end else begin
`ifdef BRIDGE_ERR_RESP_EN
                w_acc_state = ST_ERR1;
`else
                w_acc_zero  = !Hwrite;
`endif
            end
        end else begin
            w_acc_state = ST_IDLE;
        end
    end

    // Next-state and next-value logic for the sequencing registers.
    always_comb begin
        w_state_nxt  = ST_IDLE;
        w_idx_nxt    = r_idx;
        w_paddr_nxt  = r_paddr;
        w_pwrite_nxt = r_pwrite;
        w_pwdata_nxt = r_pwdata;
        w_hrdata_nxt = r_hrdata;
        case (r_state)
`ifdef BRIDGE_ERR_RESP_EN
            ST_IDLE, ST_ERR2: begin
`else
            ST_IDLE: begin
`endif
                w_state_nxt = w_acc_state;
                if (w_acc_load) begin
                    w_idx_nxt    = w_dec_idx;
                    w_paddr_nxt  = Haddr;
                    w_pwrite_nxt = Hwrite;
                end else begin
                    w_idx_nxt    = r_idx;
                end
                if (w_acc_zero) begin
                    w_hrdata_nxt = 32'h0000_0000;
                end else begin
                    w_hrdata_nxt = r_hrdata;
                end
            end
            ST_WWAIT: begin
                w_pwdata_nxt = Hwdata;
                w_state_nxt  = ST_SETUP;
            end
            ST_SETUP: w_state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (!r_pwrite) begin
                    w_hrdata_nxt = Prdata;
                end else begin
                    w_hrdata_nxt = r_hrdata;
                end
                w_state_nxt = ST_IDLE;
            end
`ifdef BRIDGE_ERR_RESP_EN
            ST_ERR1: w_state_nxt = ST_ERR2;
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they register alongside it.
    always_comb begin
        w_hready_nxt  = 1'b1;
        w_penable_nxt = 1'b0;
        w_err_nxt     = 1'b0;
        w_psel_nxt    = {NSLV{1'b0}};
        case (w_state_nxt)
            ST_WWAIT: w_hready_nxt = 1'b0;
            ST_SETUP: begin
                w_hready_nxt = 1'b0;
                w_psel_nxt   = 4'b0001 << w_idx_nxt;
            end
            ST_ACCESS: begin
                w_hready_nxt  = 1'b0;
                w_penable_nxt = 1'b1;
                w_psel_nxt    = 4'b0001 << w_idx_nxt;
            end
`ifdef BRIDGE_ERR_RESP_EN
            ST_ERR1: begin
                w_hready_nxt = 1'b0;
                w_err_nxt    = 1'b1;
            end
            ST_ERR2: w_err_nxt = 1'b1;
`endif
            default: w_hready_nxt = 1'b1;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!Hrstn) begin
            r_state   <= ST_IDLE;
            r_idx     <= 2'b00;
            r_paddr   <= 32'h0000_0000;
            r_pwrite  <= 1'b0;
            r_pwdata  <= 32'h0000_0000;
            r_hrdata  <= 32'h0000_0000;
            r_hready  <= 1'b1;
            r_hresp   <= HRESP_OKAY;
            r_psel    <= {NSLV{1'b0}};
            r_penable <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_paddr   <= w_paddr_nxt;
            r_pwrite  <= w_pwrite_nxt;
            r_pwdata  <= w_pwdata_nxt;
            r_hrdata  <= w_hrdata_nxt;
            r_hready  <= w_hready_nxt;
            r_hresp   <= hresp_code(w_err_nxt);
            r_psel    <= w_psel_nxt;
            r_penable <= w_penable_nxt;
        end
    end

    assign Hreadyout = r_hready;
    assign Hresp     = r_hresp;
    assign Hrdata    = r_hrdata;
    assign Psel      = r_psel;
    assign Penable   = r_penable;
    assign Pwrite    = r_pwrite;
    assign Paddr     = r_paddr;
    assign Pwdata    = r_pwdata;

endmodule

// File: tb/tb_ahb_apb_bridge_ctrl.sv
// Directed self-checking bench for ahb_apb_bridge_ctrl; expectations follow
// BRIDGE_ERR_RESP_EN when it is defined for the build.
module tb_ahb_apb_bridge_ctrl;

    logic        clk;
    logic        Hrstn;
    logic [1:0]  Htrans;
    logic        Hwrite;
    logic        Hreadyin;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;
    logic [3:0]  Psel;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;

    int n_vec = 0;
    int n_err = 0;

    ahb_apb_bridge_ctrl dut (
        .clk       (clk),
        .Hrstn     (Hrstn),
        .Htrans    (Htrans),
        .Hwrite    (Hwrite),
        .Hreadyin  (Hreadyin),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Hreadyout (Hreadyout),
        .Hresp     (Hresp),
        .Hrdata    (Hrdata),
        .Psel      (Psel),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Prdata    (Prdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs checked 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        Hrstn    = 1'b0;
        Htrans   = 2'b00;
        Hwrite   = 1'b0;
        Hreadyin = 1'b1;
        Haddr    = 32'h0000_0000;
        Hwdata   = 32'h0000_0000;
        Prdata   = 32'h0000_0000;
        step();
        step();
        chk("rst_hready", {31'd0, Hreadyout}, 32'd1);
        chk("rst_hresp",  {30'd0, Hresp},     32'd0);
        chk("rst_hrdata", Hrdata,             32'd0);
        chk("rst_psel",   {28'd0, Psel},      32'd0);
        chk("rst_pen",    {31'd0, Penable},   32'd0);
        chk("rst_pwrite", {31'd0, Pwrite},    32'd0);
        chk("rst_paddr",  Paddr,              32'd0);
        chk("rst_pwdata", Pwdata,             32'd0);
        Hrstn = 1'b1;
        step();

        // Read of slave 1
        Htrans = 2'b10; Hwrite = 1'b0; Haddr = 32'h8400_0010; Prdata = 32'hDEAD_BEEF;
        step();
        Htrans = 2'b00;
        chk("rd_setup_psel",  {28'd0, Psel},      32'h2);
        chk("rd_setup_pen",   {31'd0, Penable},   32'd0);
        chk("rd_setup_hrdy",  {31'd0, Hreadyout}, 32'd0);
        chk("rd_setup_paddr", Paddr,              32'h8400_0010);
        chk("rd_setup_pwr",   {31'd0, Pwrite},    32'd0);
        step();
        chk("rd_acc_psel", {28'd0, Psel},      32'h2);
        chk("rd_acc_pen",  {31'd0, Penable},   32'd1);
        chk("rd_acc_hrdy", {31'd0, Hreadyout}, 32'd0);
        step();
        chk("rd_done_hrdy",  {31'd0, Hreadyout}, 32'd1);
        chk("rd_done_data",  Hrdata,             32'hDEAD_BEEF);
        chk("rd_done_resp",  {30'd0, Hresp},     32'd0);
        chk("rd_done_psel",  {28'd0, Psel},      32'd0);
        chk("rd_done_pen",   {31'd0, Penable},   32'd0);

        // Write to slave 3
        Htrans = 2'b10; Hwrite = 1'b1; Haddr = 32'h8C00_0004;
        step();
        Htrans = 2'b00; Hwdata = 32'h1234_5678;
        chk("wr_wait_hrdy", {31'd0, Hreadyout}, 32'd0);
        chk("wr_wait_psel", {28'd0, Psel},      32'd0);
        step();
        Hwdata = 32'h0000_0000;
        chk("wr_setup_psel",  {28'd0, Psel},      32'h8);
        chk("wr_setup_pwr",   {31'd0, Pwrite},    32'd1);
        chk("wr_setup_pwd",   Pwdata,             32'h1234_5678);
        chk("wr_setup_paddr", Paddr,              32'h8C00_0004);
        chk("wr_setup_pen",   {31'd0, Penable},   32'd0);
        chk("wr_setup_hrdy",  {31'd0, Hreadyout}, 32'd0);
        step();
        chk("wr_acc_psel", {28'd0, Psel},      32'h8);
        chk("wr_acc_pen",  {31'd0, Penable},   32'd1);
        chk("wr_acc_pwd",  Pwdata,             32'h1234_5678);
        chk("wr_acc_hrdy", {31'd0, Hreadyout}, 32'd0);
        step();
        chk("wr_done_hrdy", {31'd0, Hreadyout}, 32'd1);
        chk("wr_done_psel", {28'd0, Psel},      32'd0);
        chk("wr_done_pwd",  Pwdata,             32'h1234_5678);
        chk("wr_done_hrd",  Hrdata,             32'hDEAD_BEEF);

        // Back-to-back: write slave 0, then SEQ read slave 2 in the ready cycle
        Htrans = 2'b10; Hwrite = 1'b1; Haddr = 32'h8000_0000;
        step();
        Htrans = 2'b00; Hwdata = 32'hAAAA_5555;
        chk("b2b_wait_hrdy", {31'd0, Hreadyout}, 32'd0);
        step();
        chk("b2b_w_setup_psel", {28'd0, Psel}, 32'h1);
        step();
        Prdata = 32'h0BAD_F00D;
        chk("b2b_w_acc_psel", {28'd0, Psel}, 32'h1);
        chk("b2b_w_acc_pen",  {31'd0, Penable}, 32'd1);
        step();
        chk("b2b_rdy", {31'd0, Hreadyout}, 32'd1);
        Htrans = 2'b11; Hwrite = 1'b0; Haddr = 32'h8800_0000;
        step();
        Htrans = 2'b00;
        chk("b2b_r_setup_psel",  {28'd0, Psel}, 32'h4);
        chk("b2b_r_setup_paddr", Paddr,         32'h8800_0000);
        step();
        chk("b2b_r_acc_pen", {31'd0, Penable}, 32'd1);
        step();
        chk("b2b_r_data", Hrdata, 32'h0BAD_F00D);

        // BUSY, Hreadyin low and IDLE at a mapped address never start an access
        Htrans = 2'b01; Haddr = 32'h8400_0000;
        step();
        chk("busy_psel", {28'd0, Psel},      32'd0);
        chk("busy_hrdy", {31'd0, Hreadyout}, 32'd1);
        Htrans = 2'b10; Hreadyin = 1'b0;
        step();
        chk("nrdy_psel", {28'd0, Psel},      32'd0);
        chk("nrdy_hrdy", {31'd0, Hreadyout}, 32'd1);
        Htrans = 2'b00; Hreadyin = 1'b1;
        step();
        chk("idle_psel", {28'd0, Psel},      32'd0);
        chk("idle_hrdy", {31'd0, Hreadyout}, 32'd1);
        chk("idle_hrd",  Hrdata,             32'h0BAD_F00D);

        // Window edge: last word of slave 2
        Htrans = 2'b10; Hwrite = 1'b0; Haddr = 32'h8BFF_FFFC; Prdata = 32'hCAFE_F00D;
        step();
        Htrans = 2'b00;
        chk("edge_psel", {28'd0, Psel}, 32'h4);
        step();
        step();
        chk("edge_data", Hrdata, 32'hCAFE_F00D);

        // Unmapped read
        Htrans = 2'b10; Hwrite = 1'b0; Haddr = 32'h9000_0000;
        step();
        Htrans = 2'b00;
`ifdef BRIDGE_ERR_RESP_EN
        chk("err1_hrdy", {31'd0, Hreadyout}, 32'd0);
        chk("err1_resp", {30'd0, Hresp},     32'd1);
        chk("err1_psel", {28'd0, Psel},      32'd0);
        step();
        chk("err2_hrdy", {31'd0, Hreadyout}, 32'd1);
        chk("err2_resp", {30'd0, Hresp},     32'd1);
        chk("err2_psel", {28'd0, Psel},      32'd0);
        step();
        chk("err_end_resp", {30'd0, Hresp}, 32'd0);
`else
        chk("unm_hrdy", {31'd0, Hreadyout}, 32'd1);
        chk("unm_resp", {30'd0, Hresp},     32'd0);
        chk("unm_data", Hrdata,             32'd0);
        chk("unm_psel", {28'd0, Psel},      32'd0);
        step();
        chk("unm_after_psel", {28'd0, Psel}, 32'd0);
`endif

        // Reset during ACCESS aborts the read
        Htrans = 2'b10; Hwrite = 1'b0; Haddr = 32'h8000_0008; Prdata = 32'h1111_2222;
        step();
        Htrans = 2'b00;
        step();
        chk("abort_acc_pen", {31'd0, Penable}, 32'd1);
        Hrstn = 1'b0;
        step();
        chk("abort_psel",  {28'd0, Psel},      32'd0);
        chk("abort_pen",   {31'd0, Penable},   32'd0);
        chk("abort_hrdy",  {31'd0, Hreadyout}, 32'd1);
        chk("abort_hrd",   Hrdata,             32'd0);
        chk("abort_paddr", Paddr,              32'd0);
        Hrstn = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_apb_bridge_ctrl.md
Name: ahb_apb_bridge_ctrl

Overview:
- AHB-slave to APB-master bridge controller sitting between the AHB bus and four APB peripherals.
- Accepts single AHB transfers, decodes the address to one of 4 APB slaves, and runs the APB SETUP/ACCESS sequence.
- Stalls AHB via Hreadyout while the APB access runs, and returns read data and response.
- Owns the sequencing of every Psel/Penable/Paddr/Pwdata/Pwrite driven onto the APB side.

Parameters:
- BASE_ADDR, 32'h8000_0000, base of the bridged region; must be aligned to 4*2^SLV_AW.
- SLV_AW, 26, log2 bytes per APB slave window; 4 consecutive windows, slave i at BASE_ADDR + i*2^SLV_AW.

Ports:
- clk  in  1  single bridge clock, all state on posedge.
- Hrstn  in  1  reset; synchronous, active-low.
- Htrans  in  2  AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- Hwrite  in  1  AHB direction, 1 = write.
- Hreadyin  in  1  AHB bus ready; address phase valid only when high.
- Haddr  in  32  AHB address.
- Hwdata  in  32  AHB write data, valid in the first data-phase cycle.
- Hreadyout  out  1  bridge ready; 0 = inserting wait state.
- Hresp  out  2  00 OKAY, 01 ERROR.
- Hrdata  out  32  registered read data.
- Psel  out  4  one-hot APB slave select.
- Penable  out  1  APB access phase.
- Pwrite  out  1  APB direction.
- Paddr  out  32  APB address.
- Pwdata  out  32  APB write data.
- Prdata  in  32  APB read data, sampled in the ACCESS cycle.

Behaviour:
- Reset: Hrstn low at a clk edge forces ST_IDLE and sets Hreadyout=1, Hresp=00, Hrdata=0, Psel=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0.
- Reset asserted mid-access aborts the access immediately; the APB slave sees Psel drop.
- Valid transfer: sampled only in ST_IDLE or ST_ERR2, when Hreadyin=1 and Htrans[1]=1.
- BUSY and IDLE Htrans codes are ignored and never start an access.
- Decode: mapped = Haddr[31:SLV_AW+2] == BASE_ADDR[31:SLV_AW+2]; slave index = Haddr[SLV_AW+1:SLV_AW].
- States and transitions:
  - ST_IDLE: Hreadyout=1, Hresp=00. Mapped read goes to ST_SETUP; mapped write goes to ST_WWAIT. In both cases Paddr/Pwrite/select index are latched. Unmapped transfer: see Optional Feature.
  - ST_WWAIT: Hreadyout=0; latch Pwdata<=Hwdata; go to ST_SETUP.
  - ST_SETUP: Psel[idx]=1, Penable=0, Hreadyout=0; go to ST_ACCESS.
  - ST_ACCESS: Psel[idx]=1, Penable=1, Hreadyout=0; on a read, Hrdata<=Prdata; go to ST_IDLE.
  - ST_ERR1: Hreadyout=0, Hresp=01; go to ST_ERR2.
  - ST_ERR2: Hreadyout=1, Hresp=01; accepts a new transfer exactly like ST_IDLE, otherwise goes to ST_IDLE.
- Latency: a read costs 2 wait states (Hrdata valid 3 cycles after the address phase); a write costs 3 wait states.
- Back-to-back transfers have zero idle cycles: the address is sampled in the same cycle Hreadyout returns to 1.
- Paddr, Pwrite and Pwdata are stable from ST_SETUP through ST_ACCESS and hold their value afterwards.
- Psel and Penable drop to 0 on return to ST_IDLE.
- Hrdata holds its value until the next read completes.
- Only one Psel bit is high at any time.
- Haddr is passed through unmodified; addresses at the window edges, e.g. 0x8BFF_FFFC vs 0x8C00_0000, must select adjacent slaves.

Optional Feature:
- Macro: BRIDGE_ERR_RESP_EN.
- Defined: an unmapped valid transfer goes ST_IDLE -> ST_ERR1 -> ST_ERR2, giving the two-cycle ERROR response. No APB activity.
- Undefined: an unmapped transfer completes with OKAY and zero wait states. Hreadyout stays 1, there is no APB activity, and an unmapped read loads Hrdata<=0. ST_ERR1/ST_ERR2 are not built.

Decomposition:
- Package ahb_apb_pkg holds: state enum, HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY/HRESP_ERROR, NSLV=4.
- Sub-module ahb_apb_addr_decode: combinational; Haddr in, mapped flag and 2-bit index out; shares BASE_ADDR/SLV_AW.

Test Plan:
- Reset then NONSEQ read at 0x8400_0010 with Prdata=32'hDEAD_BEEF -> Psel=4'b0010 in SETUP, Penable in the next cycle; Hreadyout low for 2 cycles; Hrdata=DEAD_BEEF with Hresp=00.
- NONSEQ write of 32'h1234_5678 to 0x8C00_0004 -> Psel=4'b1000, Pwrite=1, Pwdata=1234_5678 stable over SETUP/ACCESS; 3 wait states.
- Back-to-back write 0x8000_0000 then read 0x8800_0000 -> second address sampled the cycle Hreadyout rises; Psel goes 0001 then 0100 with no extra idle cycle.
- Htrans=BUSY and Hreadyin=0 cycles at a mapped address -> no Psel, Hreadyout stays 1.
- Read at 0x9000_0000 -> with BRIDGE_ERR_RESP_EN: Hresp=01 for 2 cycles, Hreadyout 0 then 1. Without it: OKAY, Hrdata=0. Psel=0 in both builds.
- Hrstn low during ST_ACCESS -> next cycle Psel=0, Penable=0, Hreadyout=1, Hrdata=0.
